// File: rtl/collision_engine.sv
// Per-frame collision resolver: checks the ball's next position against walls, paddle and bricks.
// Bricks are read one per clock from brick memory; the first hit ends the scan and clears it.
module collision_engine #(
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned VEL_W      = 3,
    parameter int unsigned LEN_W      = 5,
    parameter int unsigned DIM_W      = 4,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned NUM_BRICKS = 40,
    parameter int unsigned IDX_W      = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] ballX,
    input  logic [COORD_W-1:0] ballY,
    input  logic [VEL_W-1:0]   vX,
    input  logic [VEL_W-1:0]   vY,
    input  logic [COORD_W-1:0] paddleX,
    input  logic [COORD_W-1:0] paddleY,
    input  logic [LEN_W-1:0]   length,
    output logic [IDX_W-1:0]   brick_rd_index,
    input  logic [COORD_W-1:0] brickX,
    input  logic [COORD_W-1:0] brickY,
    input  logic [DIM_W-1:0]   brickW,
    input  logic [DIM_W-1:0]   brickH,
    input  logic               brickActive,
    output logic               brick_wr_en,
    output logic [IDX_W-1:0]   brick_wr_index,
    output logic               busy,
    output logic               done,
    output logic               cX,
    output logic               cY,
    output logic               cBrickX,
    output logic               cBrickY,
    output logic [IDX_W-1:0]   hit_index,
    output logic               ball_lost
);

    localparam int unsigned SW = COORD_W + 2;
    localparam logic signed [SW-1:0] XMax = SW'(SCREEN_W - 1);
    localparam logic signed [SW-1:0] YMax = SW'(SCREEN_H - 1);

    typedef enum logic [1:0] {StIdle, StFill, StScan, StDone} state_t;

    state_t r_state, w_state_next;

    logic [COORD_W-1:0] r_ballX, r_ballY, r_paddleX, r_paddleY;
    logic [VEL_W-1:0]   r_vX, r_vY;
    logic [LEN_W-1:0]   r_length;
    logic [IDX_W-1:0]   r_rd_index, r_wr_index, r_hit_index;
    logic               r_wr_en, r_cX, r_cY, r_cBrickX, r_cBrickY, r_lost;

    logic signed [SW-1:0] w_vX_ext, w_vY_ext, w_nX, w_nY;
    logic [COORD_W:0]     w_pad_right, w_bx_end, w_by_end;
    logic                 w_wall_x, w_wall_y, w_lost, w_hit_paddle;
    logic                 w_in_x, w_in_y, w_hit_brick, w_out_x, w_out_y, w_last;
    logic [IDX_W-1:0]     w_j;

    // Next position at two extra bits so off-screen values stay signed and unwrapped
    assign w_vX_ext = {{(SW-VEL_W){r_vX[VEL_W-1]}}, r_vX};
    assign w_vY_ext = {{(SW-VEL_W){r_vY[VEL_W-1]}}, r_vY};
    assign w_nX     = $signed({2'b00, r_ballX}) + w_vX_ext;
    assign w_nY     = $signed({2'b00, r_ballY}) + w_vY_ext;

    assign w_wall_x = w_nX[SW-1] || (w_nX > XMax);
    assign w_wall_y = w_nY[SW-1];
    assign w_lost   = !w_nY[SW-1] && (w_nY > YMax);

    assign w_pad_right  = {1'b0, r_paddleX} + {{(COORD_W+1-LEN_W){1'b0}}, r_length};
    assign w_hit_paddle = !r_vY[VEL_W-1] && (r_vY != '0) && (r_ballY < r_paddleY)
                          && (w_nY >= $signed({2'b00, r_paddleY}))
                          && (w_nX >= $signed({2'b00, r_paddleX}))
                          && (w_nX <= $signed({1'b0, w_pad_right}));

    assign w_bx_end    = {1'b0, brickX} + {{(COORD_W+1-DIM_W){1'b0}}, brickW};
    assign w_by_end    = {1'b0, brickY} + {{(COORD_W+1-DIM_W){1'b0}}, brickH};
    assign w_in_x      = (w_nX >= $signed({2'b00, brickX})) && (w_nX < $signed({1'b0, w_bx_end}));
    assign w_in_y      = (w_nY >= $signed({2'b00, brickY})) && (w_nY < $signed({1'b0, w_by_end}));
    assign w_hit_brick = brickActive && w_in_x && w_in_y;
    assign w_out_x     = (r_ballX < brickX) || ({1'b0, r_ballX} >= w_bx_end);
    assign w_out_y     = (r_ballY < brickY) || ({1'b0, r_ballY} >= w_by_end);

    // Data on the brick port belongs to the address issued one cycle earlier
    assign w_j    = r_rd_index - IDX_W'(1);
    assign w_last = (w_j == IDX_W'(NUM_BRICKS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (start) w_state_next = StFill;
            StFill: w_state_next = StScan;
            StScan: if (w_hit_brick || w_last) w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ballX     <= '0;
            r_ballY     <= '0;
            r_paddleX   <= '0;
            r_paddleY   <= '0;
            r_vX        <= '0;
            r_vY        <= '0;
            r_length    <= '0;
            r_rd_index  <= '0;
            r_wr_index  <= '0;
            r_hit_index <= '0;
            r_wr_en     <= 1'b0;
            r_cX        <= 1'b0;
            r_cY        <= 1'b0;
            r_cBrickX   <= 1'b0;
            r_cBrickY   <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_ballX     <= ballX;
                        r_ballY     <= ballY;
                        r_paddleX   <= paddleX;
                        r_paddleY   <= paddleY;
                        r_vX        <= vX;
                        r_vY        <= vY;
                        r_length    <= length;
                        r_rd_index  <= '0;
                        r_hit_index <= '0;
                        r_cX        <= 1'b0;
                        r_cY        <= 1'b0;
                        r_cBrickX   <= 1'b0;
                        r_cBrickY   <= 1'b0;
                        r_lost      <= 1'b0;
                    end
                end
                StFill: r_rd_index <= IDX_W'(1);
                StScan: begin
                    r_rd_index <= r_rd_index + IDX_W'(1);
                    if (w_hit_brick || w_last) begin
                        r_cX   <= w_wall_x;
                        r_cY   <= w_wall_y || w_hit_paddle;
                        r_lost <= w_lost;
                    end
                    if (w_hit_brick) begin
                        // A ball already inside the brick reflects vertically
                        r_cBrickX   <= w_out_x;
                        r_cBrickY   <= w_out_y || !w_out_x;
                        r_hit_index <= w_j;
                        r_wr_index  <= w_j;
                        r_wr_en     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign brick_rd_index = r_rd_index;
    assign brick_wr_en    = r_wr_en;
    assign brick_wr_index = r_wr_index;
    assign busy           = (r_state != StIdle);
    assign done           = (r_state == StDone);
    assign cX             = r_cX;
    assign cY             = r_cY;
    assign cBrickX        = r_cBrickX;
    assign cBrickY        = r_cBrickY;
    assign hit_index      = r_hit_index;
    assign ball_lost      = r_lost;

endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine with a registered brick-memory model and a result scoreboard.
module tb_collision_engine;

    logic       clock, reset, start;
    logic [7:0] ballX, ballY, paddleX, paddleY, brickX, brickY;
    logic [2:0] vX, vY;
    logic [4:0] length;
    logic [3:0] brickW, brickH;
    logic       brickActive, brick_wr_en, busy, done, cX, cY, cBrickX, cBrickY, ball_lost;
    logic [5:0] brick_rd_index, brick_wr_index, hit_index;

    collision_engine dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .ballX          (ballX),
        .ballY          (ballY),
        .vX             (vX),
        .vY             (vY),
        .paddleX        (paddleX),
        .paddleY        (paddleY),
        .length         (length),
        .brick_rd_index (brick_rd_index),
        .brickX         (brickX),
        .brickY         (brickY),
        .brickW         (brickW),
        .brickH         (brickH),
        .brickActive    (brickActive),
        .brick_wr_en    (brick_wr_en),
        .brick_wr_index (brick_wr_index),
        .busy           (busy),
        .done           (done),
        .cX             (cX),
        .cY             (cY),
        .cBrickX        (cBrickX),
        .cBrickY        (cBrickY),
        .hit_index      (hit_index),
        .ball_lost      (ball_lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Brick memory: registered read, hit bricks cleared through the write port
    logic [7:0]  mem_x [64];
    logic [7:0]  mem_y [64];
    logic [3:0]  mem_w [64];
    logic [3:0]  mem_h [64];
    logic        mem_act [64];
    logic [63:0] cleared = '0;
    int          wr_count = 0;
    int          last_wr_idx = -1;

    always @(posedge clock) begin
        brickX      <= mem_x[brick_rd_index];
        brickY      <= mem_y[brick_rd_index];
        brickW      <= mem_w[brick_rd_index];
        brickH      <= mem_h[brick_rd_index];
        brickActive <= mem_act[brick_rd_index] && !cleared[brick_rd_index];
        if (brick_wr_en) begin
            cleared[brick_wr_index] <= 1'b1;
            wr_count    = wr_count + 1;
            last_wr_idx = int'(brick_wr_index);
        end
    end

    typedef struct {
        int lat;
        bit cx, cy, cbx, cby, lost, hit;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(int lat, bit cx, bit cy, bit cbx, bit cby, bit lost, bit hit,
                                int idx);
        exp_t e;
        e.lat = lat; e.cx = cx; e.cy = cy; e.cbx = cbx; e.cby = cby;
        e.lost = lost; e.hit = hit; e.idx = idx;
        return e;
    endfunction

    task automatic set_ball(input logic [7:0] bx, input logic [7:0] by, input logic [2:0] vx,
                            input logic [2:0] vy);
        ballX = bx; ballY = by; vX = vx; vY = vy;
    endtask

    task automatic set_brick(input int i, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] w, input logic [3:0] h);
        mem_x[i] = x; mem_y[i] = y; mem_w[i] = w; mem_h[i] = h; mem_act[i] = 1'b1;
    endtask

    task automatic run_frame(input string tag, input exp_t e, input bit mid_start);
        exp_t q;
        int   lat;
        int   wr0;
        bit   seen;
        wr0 = wr_count;
        @(negedge clock);
        start = 1'b1;
        sb.push_back(e);
        @(posedge clock);
        #1 start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clock);
            #1 lat++;
            start = mid_start && (lat == 10);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        q = sb.pop_front();
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check({tag, "_latency"}, lat, q.lat);
            check({tag, "_busy_done"}, busy, 1);
            check({tag, "_cX"}, cX, q.cx);
            check({tag, "_cY"}, cY, q.cy);
            check({tag, "_cBrickX"}, cBrickX, q.cbx);
            check({tag, "_cBrickY"}, cBrickY, q.cby);
            check({tag, "_ball_lost"}, ball_lost, q.lost);
            if (q.hit) check({tag, "_hit_index"}, hit_index, q.idx);
        end
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_cX_hold"}, cX, q.cx);
        check({tag, "_wr_count"}, wr_count - wr0, q.hit ? 1 : 0);
        if (q.hit) check({tag, "_wr_index"}, last_wr_idx, q.idx);
    endtask

    initial begin
        int  lat;
        bit  early_done;
        int  wr0;
        reset = 1'b1;
        start = 1'b0;
        set_ball(8'd0, 8'd0, 3'd0, 3'd0);
        paddleX = 8'd60;
        paddleY = 8'd110;
        length  = 5'd16;
        for (int i = 0; i < 64; i++) begin
            mem_x[i] = 8'd0; mem_y[i] = 8'd0; mem_w[i] = 4'd0; mem_h[i] = 4'd0;
            mem_act[i] = 1'b0;
        end
        #2 reset = 1'b0;
        #2;
        check("reset_outputs", {busy, done, cX, cY, cBrickX, cBrickY, ball_lost, brick_wr_en,
                                brick_wr_index, hit_index, brick_rd_index}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Left wall, nX = -1
        set_ball(8'd1, 8'd50, 3'b110, 3'b001);
        run_frame("wall", mk(41, 1, 0, 0, 0, 0, 0, 0), 1'b0);

        // Paddle landing at nX = 71 within [60, 76]
        set_ball(8'd70, 8'd109, 3'b001, 3'b001);
        run_frame("paddle_hit", mk(41, 0, 1, 0, 0, 0, 0, 0), 1'b0);

        // nX = 81 misses the paddle
        set_ball(8'd80, 8'd109, 3'b001, 3'b001);
        run_frame("paddle_miss", mk(41, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // Entry from below into brick 5 spanning y 20..24
        set_brick(5, 8'd40, 8'd20, 4'd8, 4'd5);
        set_ball(8'd44, 8'd25, 3'b000, 3'b111);
        run_frame("brick5", mk(7, 0, 0, 0, 1, 0, 1, 5), 1'b0);

        // Corner entry; bricks 3 and 9 both contain (31,61)
        set_brick(3, 8'd31, 8'd61, 4'd4, 4'd4);
        set_brick(9, 8'd29, 8'd59, 4'd6, 4'd6);
        set_ball(8'd30, 8'd60, 3'b001, 3'b001);
        run_frame("corner", mk(5, 0, 0, 1, 1, 0, 1, 3), 1'b0);

        // Bottom edge, nY = 121
        set_ball(8'd100, 8'd119, 3'b000, 3'b010);
        run_frame("lost", mk(41, 0, 0, 0, 0, 1, 0, 0), 1'b0);

        // A start pulse mid-scan must not restart or extend it
        set_ball(8'd50, 8'd50, 3'b001, 3'b001);
        run_frame("ign_start", mk(41, 0, 0, 0, 0, 0, 0, 0), 1'b1);

        // Reset in the middle of a scan that would otherwise hit brick 30
        set_brick(30, 8'd90, 8'd50, 4'd4, 4'd4);
        set_ball(8'd91, 8'd49, 3'b000, 3'b001);
        wr0 = wr_count;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(posedge clock);
            #1 lat++;
        end
        reset = 1'b0;
        #1;
        check("rst_mid_outputs", {busy, done, cX, cY, cBrickX, cBrickY, ball_lost, brick_wr_en,
                                  brick_wr_index, hit_index, brick_rd_index}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        early_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1 if (done || busy || brick_wr_en) early_done = 1'b1;
        end
        check("rst_mid_idle", 32'(early_done), 0);
        check("rst_mid_no_write", wr_count - wr0, 0);

        // Same frame completes normally after the reset
        run_frame("brick30", mk(32, 0, 0, 0, 1, 0, 1, 30), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
